// File: rtl/rtu_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// rtu_req_arbiter_if
// Request/response bus between the RTU request arbiter and the RTU match
// engine.
//
// Signals:
//   req_valid  arbiter -> engine  lookup request pending (eng_req_valid)
//   req_data   arbiter -> engine  latched request payload (eng_req_data)
//   req_port   arbiter -> engine  index of the granted port (eng_req_port)
//   req_ready  engine -> arbiter  engine accepts the request (eng_req_ready)
//   rsp_valid  engine -> arbiter  single-cycle response strobe (eng_rsp_valid)
//   rsp_data   engine -> arbiter  response payload (eng_rsp_data)
//
// Modports:
//   master  arbiter side
//   slave   engine side
// -----------------------------------------------------------------------------
interface rtu_req_arbiter_if #(
  parameter int g_req_width = 112,
  parameter int g_rsp_width = 32
);
  logic                   req_valid;
  logic [g_req_width-1:0] req_data;
  logic [4:0]             req_port;
  logic                   req_ready;
  logic                   rsp_valid;
  logic [g_rsp_width-1:0] rsp_data;

  modport master (
    output req_valid,
    output req_data,
    output req_port,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_port,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/rtu_req_arbiter.sv
// -----------------------------------------------------------------------------
// rtu_req_arbiter
// Shares one RTU lookup engine between g_num_ports request channels. Grants are
// round-robin, one lookup is in flight at a time, the engine response is routed
// back to the requesting port, and an unanswered lookup is retired by a timeout
// with a drop response.
//
// Ports:
//   clk_sys_i    system clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   enable_i     gates new grants (in-flight lookup always completes)
//   req_valid_i  per-port request level, held until acked
//   req_data_i   per-port payloads, port i at [i*g_req_width +: g_req_width]
//   req_ack_o    one-cycle pulse: request of that port latched
//   rsp_valid_o  one-hot response-available flag
//   rsp_data_o   shared response payload
//   rsp_drop_o   response is a timeout drop (rsp_data_o is 0)
//   rsp_ack_i    per-port response consume
//   eng          engine request/response bus (master side)
//   busy_o       FSM not idle
//   timeout_o    one-cycle pulse on lookup timeout
//   stray_rsp_o  one-cycle pulse on an engine response outside WAIT_RSP
// -----------------------------------------------------------------------------
module rtu_req_arbiter #(
  parameter int g_num_ports = 6,
  parameter int g_req_width = 112,
  parameter int g_rsp_width = 32,
  parameter int g_timeout   = 255
) (
  input  logic                               clk_sys_i,
  input  logic                               rst_n_i,
  input  logic                               enable_i,
  input  logic [g_num_ports-1:0]             req_valid_i,
  input  logic [g_num_ports*g_req_width-1:0] req_data_i,
  output logic [g_num_ports-1:0]             req_ack_o,
  output logic [g_num_ports-1:0]             rsp_valid_o,
  output logic [g_rsp_width-1:0]             rsp_data_o,
  output logic                               rsp_drop_o,
  input  logic [g_num_ports-1:0]             rsp_ack_i,
  rtu_req_arbiter_if.master                  eng,
  output logic                               busy_o,
  output logic                               timeout_o,
  output logic                               stray_rsp_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_DELIVER
  } state_t;

  localparam logic [4:0]  c_last_init   = 5'(g_num_ports - 1);
  localparam logic [15:0] c_timeout_max = 16'(g_timeout - 1);

  // Registered state and outputs
  state_t                 state_reg,         state_next;
  logic [4:0]             last_grant_reg,    last_grant_next;
  logic [g_num_ports-1:0] grant_oh_reg,      grant_oh_next;
  logic [15:0]            cnt_reg,           cnt_next;
  logic [g_num_ports-1:0] req_ack_reg,       req_ack_next;
  logic [g_num_ports-1:0] rsp_valid_reg,     rsp_valid_next;
  logic [g_rsp_width-1:0] rsp_data_reg,      rsp_data_next;
  logic                   rsp_drop_reg,      rsp_drop_next;
  logic                   eng_req_valid_reg, eng_req_valid_next;
  logic [g_req_width-1:0] eng_req_data_reg,  eng_req_data_next;
  logic [4:0]             eng_req_port_reg,  eng_req_port_next;
  logic                   busy_reg,          busy_next;
  logic                   timeout_reg,       timeout_next;
  logic                   stray_reg,         stray_next;

  // Arbitration results (combinational, only used in IDLE)
  logic                   grant_found;
  logic [4:0]             grant_idx;
  logic [g_num_ports-1:0] grant_oh;
  logic [g_req_width-1:0] req_data_sel;
  logic [g_req_width-1:0] req_data_arr [g_num_ports];

  genvar gi;
  generate
    for (gi = 0; gi < g_num_ports; gi++) begin : g_split
      assign req_data_arr[gi] = req_data_i[gi*g_req_width +: g_req_width];
    end
  endgenerate

  // Round-robin pick: first the ports above last_grant, then wrap around to
  // the ports at or below it. The wrap pass includes last_grant itself, so a
  // lone requester can be re-granted, but any other pending port wins first.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    for (int i = 0; i < g_num_ports; i++) begin
      if (!grant_found && req_valid_i[i] && (i > int'(last_grant_reg))) begin
        grant_found = 1'b1;
        grant_idx   = 5'(i);
        grant_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < g_num_ports; i++) begin
      if (!grant_found && req_valid_i[i] && (i <= int'(last_grant_reg))) begin
        grant_found = 1'b1;
        grant_idx   = 5'(i);
        grant_oh[i] = 1'b1;
      end
    end
  end

  // One-hot AND-OR payload mux
  always_comb begin
    req_data_sel = '0;
    for (int i = 0; i < g_num_ports; i++) begin
      if (grant_oh[i]) begin
        req_data_sel = req_data_sel | req_data_arr[i];
      end
    end
  end

  always_comb begin
    state_next         = state_reg;
    last_grant_next    = last_grant_reg;
    grant_oh_next      = grant_oh_reg;
    cnt_next           = cnt_reg;
    req_ack_next       = '0;
    rsp_valid_next     = rsp_valid_reg;
    rsp_data_next      = rsp_data_reg;
    rsp_drop_next      = rsp_drop_reg;
    eng_req_valid_next = eng_req_valid_reg;
    eng_req_data_next  = eng_req_data_reg;
    eng_req_port_next  = eng_req_port_reg;
    timeout_next       = 1'b0;
    // A response strobe is only meaningful while a lookup is outstanding
    stray_next         = eng.rsp_valid && (state_reg != ST_WAIT_RSP);

    case (state_reg)
      ST_IDLE: begin
        if (enable_i && grant_found) begin
          state_next         = ST_ISSUE;
          last_grant_next    = grant_idx;
          grant_oh_next      = grant_oh;
          req_ack_next       = grant_oh;
          eng_req_valid_next = 1'b1;
          eng_req_data_next  = req_data_sel;
          eng_req_port_next  = grant_idx;
        end
      end

      ST_ISSUE: begin
        if (eng.req_ready) begin
          state_next         = ST_WAIT_RSP;
          eng_req_valid_next = 1'b0;
          cnt_next           = '0;
        end
      end

      ST_WAIT_RSP: begin
        if (eng.rsp_valid) begin
          // A response arriving on the timeout cycle still wins
          state_next     = ST_DELIVER;
          rsp_data_next  = eng.rsp_data;
          rsp_drop_next  = 1'b0;
          rsp_valid_next = grant_oh_reg;
        end else if (cnt_reg == c_timeout_max) begin
          state_next     = ST_DELIVER;
          rsp_data_next  = '0;
          rsp_drop_next  = 1'b1;
          rsp_valid_next = grant_oh_reg;
          timeout_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      ST_DELIVER: begin
        // Only the granted port's ack retires the response
        if (|(rsp_ack_i & grant_oh_reg)) begin
          state_next     = ST_IDLE;
          rsp_valid_next = '0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg         <= ST_IDLE;
      last_grant_reg    <= c_last_init;
      grant_oh_reg      <= '0;
      cnt_reg           <= '0;
      req_ack_reg       <= '0;
      rsp_valid_reg     <= '0;
      rsp_data_reg      <= '0;
      rsp_drop_reg      <= 1'b0;
      eng_req_valid_reg <= 1'b0;
      eng_req_data_reg  <= '0;
      eng_req_port_reg  <= '0;
      busy_reg          <= 1'b0;
      timeout_reg       <= 1'b0;
      stray_reg         <= 1'b0;
    end else begin
      state_reg         <= state_next;
      last_grant_reg    <= last_grant_next;
      grant_oh_reg      <= grant_oh_next;
      cnt_reg           <= cnt_next;
      req_ack_reg       <= req_ack_next;
      rsp_valid_reg     <= rsp_valid_next;
      rsp_data_reg      <= rsp_data_next;
      rsp_drop_reg      <= rsp_drop_next;
      eng_req_valid_reg <= eng_req_valid_next;
      eng_req_data_reg  <= eng_req_data_next;
      eng_req_port_reg  <= eng_req_port_next;
      busy_reg          <= busy_next;
      timeout_reg       <= timeout_next;
      stray_reg         <= stray_next;
    end
  end

  assign req_ack_o     = req_ack_reg;
  assign rsp_valid_o   = rsp_valid_reg;
  assign rsp_data_o    = rsp_data_reg;
  assign rsp_drop_o    = rsp_drop_reg;
  assign eng.req_valid = eng_req_valid_reg;
  assign eng.req_data  = eng_req_data_reg;
  assign eng.req_port  = eng_req_port_reg;
  assign busy_o        = busy_reg;
  assign timeout_o     = timeout_reg;
  assign stray_rsp_o   = stray_reg;

endmodule

// File: tb/tb_rtu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rtu_req_arbiter
// Directed bench for rtu_req_arbiter with 6 ports and a 16-cycle timeout.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_rtu_req_arbiter;

  localparam int NP = 6;
  localparam int RW = 112;
  localparam int SW = 32;
  localparam int TO = 16;

  logic             clk_sys = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [NP-1:0]    req_valid;
  logic [NP*RW-1:0] req_data;
  logic [NP-1:0]    req_ack;
  logic [NP-1:0]    rsp_valid;
  logic [SW-1:0]    rsp_data;
  logic             rsp_drop;
  logic [NP-1:0]    rsp_ack;
  logic             busy;
  logic             timeout;
  logic             stray;

  int n_vec = 0;
  int n_err = 0;

  rtu_req_arbiter_if #(.g_req_width(RW), .g_rsp_width(SW)) eng_if ();

  rtu_req_arbiter #(
    .g_num_ports (NP),
    .g_req_width (RW),
    .g_rsp_width (SW),
    .g_timeout   (TO)
  ) dut (
    .clk_sys_i   (clk_sys),
    .rst_n_i     (rst_n),
    .enable_i    (enable),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ack_o   (req_ack),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_drop_o  (rsp_drop),
    .rsp_ack_i   (rsp_ack),
    .eng         (eng_if.master),
    .busy_o      (busy),
    .timeout_o   (timeout),
    .stray_rsp_o (stray)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [RW-1:0] pay(input int p);
    logic [7:0] b;
    b = 8'(p) + 8'h10;
    return {14{b}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_eng_req();
    for (int i = 0; i < 20; i++) begin
      if (eng_if.req_valid) break;
      tick();
    end
    chk("wait_eng_req", 128'(eng_if.req_valid), 128'(1));
  endtask

  // Engine answers in WAIT_RSP; port acks its response.
  task automatic respond_and_ack(input logic [NP-1:0] exp_oh, input logic [SW-1:0] d);
    eng_if.rsp_valid = 1'b1;
    eng_if.rsp_data  = d;
    tick();
    eng_if.rsp_valid = 1'b0;
    chk("rsp_valid", 128'(rsp_valid), 128'(exp_oh));
    chk("rsp_data",  128'(rsp_data),  128'(d));
    chk("rsp_drop",  128'(rsp_drop),  128'(0));
    rsp_ack = exp_oh;
    tick();
    rsp_ack = '0;
    chk("rsp_valid_clr", 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0] oh;
    rst_n            = 1'b0;
    enable           = 1'b1;
    req_valid        = '0;
    rsp_ack          = '0;
    eng_if.req_ready = 1'b1;
    eng_if.rsp_valid = 1'b0;
    eng_if.rsp_data  = '0;
    for (int i = 0; i < NP; i++) req_data[i*RW +: RW] = pay(i);

    // Reset state
    tick();
    tick();
    chk("rst_busy",     128'(busy),             128'(0));
    chk("rst_eng_vld",  128'(eng_if.req_valid), 128'(0));
    chk("rst_ack",      128'(req_ack),          128'(0));
    chk("rst_rsp_vld",  128'(rsp_valid),        128'(0));
    rst_n = 1'b1;
    tick();

    // Fairness: all ports pending for 14 lookups
    req_valid = '1;
    for (int k = 0; k < 14; k++) begin
      oh = NP'(1) << (k % NP);
      wait_eng_req();
      chk("fair_port", 128'(eng_if.req_port), 128'(k % NP));
      chk("fair_ack",  128'(req_ack),         128'(oh));
      tick();
      respond_and_ack(oh, SW'(32'h100 + k));
    end
    req_valid = '0;
    tick();

    // Single request from port 2
    req_valid = 6'b000100;
    tick();
    chk("single_ack",  128'(req_ack),          128'(6'b000100));
    chk("single_vld",  128'(eng_if.req_valid), 128'(1));
    chk("single_port", 128'(eng_if.req_port),  128'(2));
    chk("single_data", 128'(eng_if.req_data),  128'(pay(2)));
    chk("single_busy", 128'(busy),             128'(1));
    req_valid = '0;
    tick();
    chk("single_ack_pulse", 128'(req_ack),          128'(0));
    chk("single_vld_drop",  128'(eng_if.req_valid), 128'(0));
    tick();
    tick();
    respond_and_ack(6'b000100, 32'h0000_0004);
    chk("single_idle", 128'(busy), 128'(0));

    // Backpressure: engine not ready for 10 cycles, port 3
    eng_if.req_ready = 1'b0;
    req_valid = 6'b001000;
    tick();
    chk("bp_ack", 128'(req_ack), 128'(6'b001000));
    req_valid = '0;
    req_data[3*RW +: RW] = '1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_vld",  128'(eng_if.req_valid), 128'(1));
      chk("bp_data", 128'(eng_if.req_data),  128'(pay(3)));
      chk("bp_to",   128'(timeout),          128'(0));
    end
    req_data[3*RW +: RW] = pay(3);
    eng_if.req_ready = 1'b1;
    tick();
    chk("bp_vld_drop", 128'(eng_if.req_valid), 128'(0));
    respond_and_ack(6'b001000, 32'hABCD_1234);

    // Timeout: port 5, engine silent
    req_valid = 6'b100000;
    tick();
    req_valid = '0;
    chk("to_port", 128'(eng_if.req_port), 128'(5));
    tick();
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k < TO) begin
        chk("to_early", 128'(timeout), 128'(0));
      end else begin
        chk("to_pulse",   128'(timeout),   128'(1));
        chk("to_rsp_vld", 128'(rsp_valid), 128'(6'b100000));
        chk("to_drop",    128'(rsp_drop),  128'(1));
        chk("to_data",    128'(rsp_data),  128'(0));
      end
    end
    // Late engine response and an ack on a non-granted port
    eng_if.rsp_valid = 1'b1;
    eng_if.rsp_data  = 32'hDEAD_BEEF;
    rsp_ack = 6'b000001;
    tick();
    eng_if.rsp_valid = 1'b0;
    rsp_ack = '0;
    chk("to_pulse_end",  128'(timeout),   128'(0));
    chk("late_stray",    128'(stray),     128'(1));
    chk("late_data",     128'(rsp_data),  128'(0));
    chk("late_drop",     128'(rsp_drop),  128'(1));
    chk("wrong_ack_vld", 128'(rsp_valid), 128'(6'b100000));
    rsp_ack = 6'b100000;
    tick();
    rsp_ack = '0;
    chk("to_rsp_clr", 128'(rsp_valid), 128'(0));
    chk("stray_pulse", 128'(stray),    128'(0));

    // Enable gating: ports 1 and 4
    enable = 1'b0;
    req_valid = 6'b010010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en_no_ack", 128'(req_ack), 128'(0));
    end
    chk("en_no_busy", 128'(busy), 128'(0));
    enable = 1'b1;
    tick();
    chk("en_ack1",  128'(req_ack),         128'(6'b000010));
    chk("en_port1", 128'(eng_if.req_port), 128'(1));
    req_valid = 6'b010000;
    tick();
    respond_and_ack(6'b000010, 32'h11);
    wait_eng_req();
    chk("en_ack4",  128'(req_ack),         128'(6'b010000));
    chk("en_port4", 128'(eng_if.req_port), 128'(4));
    req_valid = '0;
    tick();
    respond_and_ack(6'b010000, 32'h44);

    // Reset in WAIT_RSP
    req_valid = 6'b001000;
    tick();
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy",     128'(busy),             128'(0));
    chk("arst_eng_vld",  128'(eng_if.req_valid), 128'(0));
    chk("arst_eng_port", 128'(eng_if.req_port),  128'(0));
    chk("arst_eng_data", 128'(eng_if.req_data),  128'(0));
    chk("arst_rsp_data", 128'(rsp_data),         128'(0));
    chk("arst_rsp_vld",  128'(rsp_valid),        128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    eng_if.rsp_valid = 1'b1;
    eng_if.rsp_data  = 32'h5;
    tick();
    eng_if.rsp_valid = 1'b0;
    chk("arst_stray",   128'(stray),     128'(1));
    chk("arst_no_rsp",  128'(rsp_valid), 128'(0));
    req_valid = 6'b010001;
    tick();
    chk("arst_ack0",  128'(req_ack),         128'(6'b000001));
    chk("arst_port0", 128'(eng_if.req_port), 128'(0));
    req_valid = '0;
    tick();
    respond_and_ack(6'b000001, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
